hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage. It is the producer of the HI/LO results that the decode-side forwarding logic consumes.
- Accepts MULT/MULTU/DIV/DIVU operands from execute and computes the results: a pipelined multiplier, and a radix-2 restoring divider that iterates one bit per cycle.
- Signals busy so the hazard unit stalls the front end.
- Presents the {hi, lo} result with a 2-bit write enable that travels down to writeback.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- MUL_LATENCY, 2, cycles from accepted start to done for MULT/MULTU (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  input  WIDTH  rs operand (multiplicand / dividend); sampled with start.
- b  input  WIDTH  rt operand (multiplier / divisor); sampled with start.
- flush  input  1  abort any in-flight operation (exception/branch squash).
- busy  output  1  operation in flight, result not yet available.
- done  output  1  one-cycle pulse: hi/lo valid this cycle.
- hi  output  WIDTH  MULT: upper product; DIV: remainder.
- lo  output  WIDTH  MULT: lower product; DIV: quotient.
- hilo_write_en  output  2  bit1 = write HI, bit0 = write LO; equals 2'b11 when done, else 2'b00.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, hilo_write_en=00, all internal counters and registers 0.
- States and transitions:
  - IDLE: start=1 and flush=0 latch op/a/b, then go to MUL (op[1]=0) or DIV (op[1]=1).
  - MUL: count MUL_LATENCY-1 cycles, then DONE.
  - DIV: 32 iterations, then a sign-fix cycle, then DONE.
  - DONE: drives done=1 and hilo_write_en=11 for exactly one cycle, then returns to IDLE.
- Latency, with start accepted in cycle 0:
  - MULT: done in cycle MUL_LATENCY, i.e. cycle 2 by default.
  - DIV: done in cycle 33.
- busy timing:
  - busy=1 from cycle 1 through cycle N-1; busy=0 in the done cycle and in IDLE.
  - busy is a registered output; it is never combinational from start.
- Holding and acceptance:
  - hi/lo hold their last result until the next DONE. They are not cleared by a new start.
  - start while busy or in DONE is ignored; no queueing.
  - In the DONE cycle itself, a start is not accepted; the earliest next accept is the following IDLE cycle.
- Multiply:
  - Full 2*WIDTH product. MULT is signed x signed, MULTU is unsigned x unsigned.
  - {hi, lo} = product.
- Divide:
  - Operate on magnitudes.
  - Quotient is negated when a[31]^b[31] and op=DIV.
  - Remainder takes the sign of a for DIV.
  - The most-negative dividend (0x80000000 / -1) yields quotient 0x80000000, remainder 0.
- Divide by zero (b=0): still runs the full 33 cycles. Result is lo=all-ones and hi=a, for both DIV and DIVU.
- Flush:
  - Takes effect at the next edge in any state: state returns to IDLE and busy drops to 0 in the next cycle.
  - No done is produced; hi/lo keep their previous values.
  - flush in the DONE cycle suppresses nothing, since done is already visible; state still goes to IDLE.
  - flush and start in the same cycle in IDLE: flush wins, no operation starts.
- Reset mid-operation: behaves as the reset values above; no done.
- Width rules: internal divider remainder register is WIDTH+1 bits; counter is 6 bits.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy=1 in cycle 1; done=1, hilo_write_en=11 in cycle 2; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> cycle 2: hi=0xFFFFFFFE, lo=0x00000001. Repeat with op=MULT -> hi=0, lo=1.
- DIVU a=100, b=7 -> done in cycle 33, busy=1 in cycles 1..32, lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234, b=0 -> cycle 33: lo=0xFFFFFFFF, hi=0x1234.
- Start DIV, then assert flush in cycle 10 -> busy=0 from cycle 11, no done, hi/lo unchanged. MULT started in cycle 11 completes in cycle 13. start+flush together in IDLE -> nothing starts.
- Start DIV, then assert reset in cycle 5 -> all outputs 0 next cycle. start held high during busy -> ignored, exactly one done observed.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing the HI/LO pair with a 2-bit write enable.
// Multiplier has a single register stage; divider is radix-2 restoring, one quotient bit per cycle.
module hilo_muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       hilo_write_en
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [1:0]         op_s;
    logic [WIDTH-1:0]   a_s, b_s, a_mag, b_mag;
    logic               a_neg, b_neg, is_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0] rem,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r_sh, diff;
        r_sh = {rem[WIDTH-1:0], q[WIDTH-1]};
        diff = r_sh - {1'b0, d};
        if (!diff[WIDTH]) return {diff, q[WIDTH-2:0], 1'b1};
        else              return {r_sh, q[WIDTH-2:0], 1'b0};
    endfunction

    // In IDLE the operands come straight from the ports so the accept edge can do useful work.
    always_comb begin
        op_s      = (state_q == S_IDLE) ? op : op_q;
        a_s       = (state_q == S_IDLE) ? a  : a_q;
        b_s       = (state_q == S_IDLE) ? b  : b_q;
        is_signed = ~op_s[0];
        a_neg     = is_signed & a_s[WIDTH-1];
        b_neg     = is_signed & b_s[WIDTH-1];
        a_mag     = a_neg ? -a_s : a_s;
        b_mag     = b_neg ? -b_s : b_s;
        a_ext     = {{WIDTH{a_neg}}, a_s};
        b_ext     = {{WIDTH{b_neg}}, b_s};
        prod      = a_ext * b_ext;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = a;
                    b_d  = b;
                    if (op[1]) begin
                        // First of the WIDTH iterations runs on the accept edge.
                        {rem_d, quo_d} = div_step('0, a_mag, b_mag);
                        cnt_d   = 6'd1;
                        state_d = S_DIV;
                    end else if (MUL_LATENCY == 1) begin
                        {hi_d, lo_d} = prod;
                        state_d      = S_DONE;
                    end else begin
                        cnt_d   = 6'd0;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MUL_LATENCY - 2)) begin
                    {hi_d, lo_d} = prod;
                    state_d      = S_DONE;
                end
            end
            S_DIV: begin
                {rem_d, quo_d} = div_step(rem_q, quo_q, b_mag);
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = a_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    lo_d = (a_neg ^ b_neg) ? -quo_q : quo_q;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy          = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done          = (state_q == S_DONE);
    assign hilo_write_en = {2{done}};
    assign hi            = hi_q;
    assign lo            = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed table, random ops vs arithmetic model,
// and hand-written flush/reset/held-start sequences.
module tb_hilo_muldiv_unit;

    localparam int W   = 32;
    localparam int ML  = 2;
    localparam int DL  = 33;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [1:0]   hilo_write_en;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_hi, last_lo;

    hilo_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .hilo_write_en(hilo_write_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, eh, el;
        int           lat;
        string        nm;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference built from plain SV arithmetic, not from any restoring algorithm.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        int     ix, iy, iq, ir;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            2'b01: return {32'h0, x} * {32'h0, y};
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (o == 2'b11) return {x % y, x / y};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                ix = $signed(x);
                iy = $signed(y);
                iq = ix / iy;
                ir = ix % iy;
                return {ir, iq};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input int lat, input string nm);
        int   cyc;
        logic busy_bad;
        op = o; a = ia; b = ib; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " busy_run"}, 64'(busy_bad), 64'(0));
        chk({nm, " busy_done"}, 64'(busy), 64'(0));
        chk({nm, " we"}, 64'(hilo_write_en), 64'(2'b11));
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        last_hi = eh;
        last_lo = el;
        tick();
        chk({nm, " done_clear"}, 64'(done), 64'(0));
    endtask

    vec_t vecs[$];

    initial begin
        int   ndone;
        logic [63:0] r;
        logic [1:0]  ro;
        logic [W-1:0] ra, rb;

        vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, ML, "mult_neg"});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML, "multu_max"});
        vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, ML, "mult_m1"});
        vecs.push_back('{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       DL, "divu_100_7"});
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DL, "div_m7_2"});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DL, "div_minneg"});
        vecs.push_back('{2'b11, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, DL, "divu_by0"});
        vecs.push_back('{2'b10, 32'hFFFFFF00, 32'h0,        32'hFFFFFF00, 32'hFFFFFFFF, DL, "div_by0"});

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst hi", 64'(hi), 64'(0));
        chk("rst lo", 64'(lo), 64'(0));
        chk("rst we", 64'(hilo_write_en), 64'(0));

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].lat, vecs[i].nm);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            r = ref_model(ro, ra, rb);
            run_op(ro, ra, rb, r[63:32], r[31:0], ro[1] ? DL : ML, $sformatf("rnd%0d", i));
        end

        // Flush a divide in cycle 10, then a multiply accepted in cycle 11.
        ndone = 0;
        op = 2'b10; a = 32'd12345; b = 32'd11; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) ndone++;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'(0));
        chk("flush done", 64'(done | (ndone != 0)), 64'(0));
        chk("flush hi", 64'(hi), 64'(last_hi));
        chk("flush lo", 64'(lo), 64'(last_lo));
        r = ref_model(2'b00, 32'hFFFFFF9C, 32'd77);
        run_op(2'b00, 32'hFFFFFF9C, 32'd77, r[63:32], r[31:0], ML, "post_flush_mult");

        // start+flush together in IDLE must not launch anything.
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("sf busy", 64'(busy), 64'(0));
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("sf no_done", 64'(ndone), 64'(0));
        chk("sf hi", 64'(hi), 64'(last_hi));

        // Reset in cycle 5 of a divide clears everything.
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst done", 64'(done), 64'(0));
        chk("midrst hi", 64'(hi), 64'(0));
        chk("midrst lo", 64'(lo), 64'(0));
        chk("midrst we", 64'(hilo_write_en), 64'(0));
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("midrst no_done", 64'(ndone), 64'(0));

        // start held through busy and DONE is accepted once only.
        op = 2'b11; a = 32'd50; b = 32'd6; start = 1'b1;
        ndone = 0;
        for (int c = 0; c <= DL; c++) begin
            if (done) ndone++;
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("held ndone", 64'(ndone), 64'(1));
        chk("held lo", 64'(lo), 64'(8));
        chk("held hi", 64'(hi), 64'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
